// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the 8-digit 7-segment display driver.
//   NUM_DIGITS      number of multiplexed digits
//   seg_t           7-bit segment pattern {a,b,c,d,e,f,g}, 1 = lit
//   SEG_0..SEG_9    patterns for BCD digits 0-9
//   SEG_BLANK       pattern shown for BCD codes 10-15
//   COM_OFF/DATA_OFF  output values that switch every digit off
//   bcd_to_seg()    BCD nibble to segment pattern lookup
// ----------------------------------------------------------------------------
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_BLANK = 7'b0000000;

  localparam logic [7:0] COM_OFF  = 8'hFF;
  localparam logic [7:0] DATA_OFF = 8'h00;

  function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
    seg_t seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_ctrl_if.sv
// ----------------------------------------------------------------------------
// seg7_ctrl_if
// Bundles the digit inputs and the display outputs of seg7_ctrl.
//   DIG0..DIG7  segment pattern per digit, DIG0 is the leftmost digit
//   SEG_COM     digit select, active-low, bit 7 = DIG0 ... bit 0 = DIG7
//   SEG_DATA    {a,b,c,d,e,f,g,dp}, active-high, dp always 0
// Modports:
//   master  digit source, observes the display outputs
//   slave   the display driver
// ----------------------------------------------------------------------------
interface seg7_ctrl_if;
  import seg7_pkg::*;

  seg_t       DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7;
  logic [7:0] SEG_COM;
  logic [7:0] SEG_DATA;

  modport master (
    output DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7,
    input  SEG_COM, SEG_DATA
  );

  modport slave (
    input  DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7,
    output SEG_COM, SEG_DATA
  );
endinterface

// File: rtl/seg7_scan_timer.sv
// ----------------------------------------------------------------------------
// seg7_scan_timer
// Prescaler counting 0..SCAN_DIV-1 and the 3-bit digit index it advances.
//   CLK     system clock
//   RST     asynchronous active-high reset (prescaler and index to 0)
//   tick_o  high in the cycle where the prescaler equals SCAN_DIV-1
//   idx_o   currently selected digit, wraps 7 -> 0
// ----------------------------------------------------------------------------
module seg7_scan_timer #(
  parameter int unsigned SCAN_DIV = 10000
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       tick_o,
  output logic [2:0] idx_o
);

  // A 1-bit counter is kept for SCAN_DIV=1; it simply stays at 0.
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic          tick;

  assign tick = (presc_q == LAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? 3'(idx_q + 3'd1) : idx_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, regardless of process evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  assign tick_o = tick;
  assign idx_o  = idx_q;

endmodule

// File: rtl/seg7_ctrl.sv
// ----------------------------------------------------------------------------
// seg7_ctrl
// Time-multiplexed driver for an 8-digit common-cathode 7-segment display.
// Each digit is selected for SCAN_DIV cycles; outputs are registered and
// refreshed every cycle from the live (unlatched) digit inputs.
//   CLK   system clock
//   RST   asynchronous active-high reset (SEG_COM=FF, SEG_DATA=00)
//   bus   seg7_ctrl_if.slave: DIG0..DIG7 in, SEG_COM/SEG_DATA out
// Parameter SCAN_DIV: cycles per digit slot, 1..2^20.
// Optional macro SEG7_DEGHOST_EN: blanks the outputs for one cycle after
// every scan tick (requires SCAN_DIV >= 2).
// ----------------------------------------------------------------------------
module seg7_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 10000
) (
  input  logic        CLK,
  input  logic        RST,
  seg7_ctrl_if.slave  bus
);

  logic       tick;
  logic [2:0] idx;

  seg7_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan_timer (
    .CLK    (CLK),
    .RST    (RST),
    .tick_o (tick),
    .idx_o  (idx)
  );

  seg_t       dig_arr [NUM_DIGITS];
  logic [7:0] seg_com_q, seg_com_d;
  logic [7:0] seg_data_q, seg_data_d;

  always_comb begin
    dig_arr[0] = bus.DIG0;
    dig_arr[1] = bus.DIG1;
    dig_arr[2] = bus.DIG2;
    dig_arr[3] = bus.DIG3;
    dig_arr[4] = bus.DIG4;
    dig_arr[5] = bus.DIG5;
    dig_arr[6] = bus.DIG6;
    dig_arr[7] = bus.DIG7;
  end

  // NOTE: every output of this block gets a value before any condition, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    seg_com_d  = ~(8'b1000_0000 >> idx);
    seg_data_d = {dig_arr[idx], 1'b0};
`ifdef SEG7_DEGHOST_EN
    // The index moves at the end of the tick cycle; blanking the value
    // registered there keeps the old and new digit from overlapping.
    if (tick) begin
      seg_com_d  = COM_OFF;
      seg_data_d = DATA_OFF;
    end
`endif
  end

`ifndef SEG7_DEGHOST_EN
  logic unused_tick;
  assign unused_tick = tick;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seg_com_q  <= COM_OFF;
      seg_data_q <= DATA_OFF;
    end else begin
      seg_com_q  <= seg_com_d;
      seg_data_q <= seg_data_d;
    end
  end

  assign bus.SEG_COM  = seg_com_q;
  assign bus.SEG_DATA = seg_data_q;

endmodule

// File: tb/tb_seg7_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg7_ctrl
// Two instances share clock, reset and digit inputs: one with SCAN_DIV=4 and
// one with the fastest legal scan (1, or 2 when SEG7_DEGHOST_EN is defined).
// The stimulus process pushes the expected outputs for every upcoming edge
// into a queue; a monitor pops and compares after each rising edge.
// ----------------------------------------------------------------------------
module tb_seg7_ctrl;
  import seg7_pkg::*;

  localparam int DIV_A = 4;
`ifdef SEG7_DEGHOST_EN
  localparam int DIV_B = 2;
`else
  localparam int DIV_B = 1;
`endif

  logic CLK;
  logic RST;

  seg7_ctrl_if bus_a ();
  seg7_ctrl_if bus_b ();

  seg7_ctrl #(.SCAN_DIV(DIV_A)) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a.slave));
  seg7_ctrl #(.SCAN_DIV(DIV_B)) dut_b (.CLK(CLK), .RST(RST), .bus(bus_b.slave));

  typedef struct packed {
    logic [7:0] com_a;
    logic [7:0] data_a;
    logic [7:0] com_b;
    logic [7:0] data_b;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;   // cycles since reset release
  logic [7:0][6:0]  digs;      // digs[k] drives DIGk

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: in cycle c after reset the scan is in slot floor(c/div),
  // digit (slot mod 8); the register shows that at the following edge.
  function automatic void model(input int c, input int div, input logic rst,
                                input logic [7:0][6:0] d,
                                output logic [7:0] com, output logic [7:0] data);
    int digit;
    com  = 8'hFF;
    data = 8'h00;
    if (!rst) begin
      digit = (c / div) % NUM_DIGITS;
      com[7 - digit] = 1'b0;
      data = {d[digit], 1'b0};
`ifdef SEG7_DEGHOST_EN
      if ((c % div) == div - 1) begin
        com  = 8'hFF;
        data = 8'h00;
      end
`endif
    end
  endfunction

  task automatic drive_bus();
    bus_a.DIG0 = digs[0]; bus_a.DIG1 = digs[1]; bus_a.DIG2 = digs[2]; bus_a.DIG3 = digs[3];
    bus_a.DIG4 = digs[4]; bus_a.DIG5 = digs[5]; bus_a.DIG6 = digs[6]; bus_a.DIG7 = digs[7];
    bus_b.DIG0 = digs[0]; bus_b.DIG1 = digs[1]; bus_b.DIG2 = digs[2]; bus_b.DIG3 = digs[3];
    bus_b.DIG4 = digs[4]; bus_b.DIG5 = digs[5]; bus_b.DIG6 = digs[6]; bus_b.DIG7 = digs[7];
  endtask

  // Apply current inputs, record what the next edge must produce, then
  // advance to the following falling edge.
  task automatic cycle();
    exp_t       e;
    logic [7:0] ca, da, cb, db;
    drive_bus();
    model(cyc, DIV_A, RST, digs, ca, da);
    model(cyc, DIV_B, RST, digs, cb, db);
    e.com_a = ca; e.data_a = da; e.com_b = cb; e.data_b = db;
    sb.push_back(e);
    if (RST) cyc = 0;
    else     cyc++;
    @(negedge CLK);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=0 required=1 entries at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("com_a",  bus_a.SEG_COM,  e.com_a);
        check("data_a", bus_a.SEG_DATA, e.data_a);
        check("com_b",  bus_b.SEG_COM,  e.com_b);
        check("data_b", bus_b.SEG_DATA, e.data_b);
        if (e.com_a != 8'hFF)
          check("one_low_a", 8'($countones(~bus_a.SEG_COM)), 8'd1);
        if (e.com_b != 8'hFF)
          check("one_low_b", 8'($countones(~bus_b.SEG_COM)), 8'd1);
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    RST  = 1'b1;
    digs = '0;

    // Held reset: outputs off.
    repeat (3) cycle();

    // "74" on the two leftmost digits, then a couple of full frames.
    digs[0] = SEG_7;
    digs[1] = SEG_4;
    RST = 1'b0;
    repeat (40) cycle();

    // Live input change in the middle of slot 0 of the SCAN_DIV=4 instance.
    digs[0] = 7'b0110000;
    guard = 0;
    while ((cyc % (8 * DIV_A)) != 1 && guard < 100) begin
      cycle();
      guard++;
    end
    digs[0] = 7'b1111111;
    repeat (6) cycle();

    // Asynchronous reset between edges while the DIV_A instance is on digit 5.
    guard = 0;
    while ((((cyc / DIV_A) % 8) != 5 || (cyc % DIV_A) != 2) && guard < 100) begin
      cycle();
      guard++;
    end
    RST = 1'b1;
    #1;
    check("async_com_a",  bus_a.SEG_COM,  8'hFF);
    check("async_data_a", bus_a.SEG_DATA, 8'h00);
    check("async_com_b",  bus_b.SEG_COM,  8'hFF);
    check("async_data_b", bus_b.SEG_DATA, 8'h00);
    repeat (2) cycle();
    RST = 1'b0;
    repeat (12) cycle();

    // Random digits (mostly decoded BCD) with occasional resets.
    repeat (300) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if ($urandom_range(0, 3) == 0) digs[k] = 7'($urandom);
        else                           digs[k] = bcd_to_seg(4'($urandom_range(0, 15)));
      end
      RST = ($urandom_range(0, 60) == 0);
      cycle();
    end
    RST = 1'b0;
    repeat (40) cycle();

    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_ctrl.md
Name: seg7_ctrl

Overview:
- Time-multiplexed driver for an 8-digit common-cathode 7-segment display.
- Accepts eight pre-decoded 7-bit segment patterns, one per digit, and scans them onto a shared segment bus with an active-low digit-select bus.
- Sits after the binary-to-BCD and BCD-to-7-segment stages; the top level feeds decoded digits into DIG0/DIG1 and ties unused digits to 0.

Parameters:
- SCAN_DIV, 10000, CLK cycles per digit slot. Legal range 1..2^20; 1 means the scan advances every cycle.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset: one clock; reset is asynchronous and active-high.
- DIG0..DIG7  in  7 each  segment pattern {a,b,c,d,e,f,g}, 1 = lit. DIG0 is the leftmost digit.
- SEG_COM  out  8  digit select, active-low. Bit 7 selects DIG0 and bit 0 selects DIG7.
- SEG_DATA  out  8  {a,b,c,d,e,f,g,dp}, active-high. dp (bit 0) is always 0.

Behaviour:
- Reset (async, RST=1):
  - prescaler = 0, digit index = 0;
  - SEG_COM = 8'hFF (all digits off), SEG_DATA = 8'h00.
- Prescaler:
  - counts 0..SCAN_DIV-1 and wraps to 0;
  - the cycle in which it equals SCAN_DIV-1 is the scan tick.
- Digit index (3-bit):
  - increments on the scan tick and wraps 7 to 0;
  - no other way to advance it.
- Outputs are registered and updated every cycle from the current index i:
  - SEG_COM = ~(8'b1000_0000 >> i);
  - SEG_DATA = {DIGi, 1'b0}.
- Latency:
  - one CLK from an index change or DIGx change to the outputs;
  - first post-reset edge gives SEG_COM = 8'h7F and SEG_DATA = {DIG0,0}.
- Slot timing: each digit is driven for exactly SCAN_DIV cycles; a full frame is 8*SCAN_DIV cycles.
- Exactly one SEG_COM bit is low at any time outside reset and outside deghost cycles.
- A DIGx change mid-slot is visible on the next edge if x is the selected digit. Inputs are not latched.
- RST asserted mid-scan immediately forces the reset values. After release, scanning restarts at DIG0 with a full SCAN_DIV slot.
- SCAN_DIV=1: the index advances every cycle and SEG_COM rotates 7F, BF, DF, …, FE, 7F.

Optional Feature:
- Macro SEG7_DEGHOST_EN.
- Defined:
  - in the cycle following each scan tick, outputs are blanked: SEG_COM = 8'hFF, SEG_DATA = 8'h00;
  - the new digit's outputs then appear one cycle later;
  - the digit is lit for SCAN_DIV-1 cycles per slot; SCAN_DIV must be ≥ 2.
- Undefined: no blanking cycle; behaviour exactly as above.

Decomposition:
- Package seg7_pkg:
  - NUM_DIGITS = 8.
  - Segment constants for BCD 0-9 ({a..g}): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - BLANK = 0000000, used for BCD codes 10-15.
- One sub-module: seg7_scan_timer, holding the prescaler and the 3-bit digit index and outputting the tick and the index.
- The digit mux and output registers stay in seg7_ctrl.

Test Plan:
- Reset check: SCAN_DIV=4, hold RST → SEG_COM = FF, SEG_DATA = 00; release → SEG_COM = 7F, SEG_DATA = {DIG0,0} on the first edge.
- Value 74: DIG0 = 1110000 ("7"), DIG1 = 0110011 ("4"), others 0, SCAN_DIV=4.
  - SEG_COM = 7F with SEG_DATA = E0 for 4 cycles;
  - then SEG_COM = BF with SEG_DATA = 66 for 4 cycles;
  - then SEG_DATA = 00 for slots 2-7.
- Wrap: SCAN_DIV=1 → SEG_COM sequence 7F, BF, DF, EF, F7, FB, FD, FE, 7F; exactly one low bit in every cycle.
- Async reset mid-scan: assert RST between edges while at index 5 → SEG_COM = FF with no clock edge needed; after release, restart at 7F.
- Live input: change DIG0 from 0110000 to 1111111 mid-slot 0 → SEG_DATA goes from 60 to FE on the next edge.
- SEG7_DEGHOST_EN, SCAN_DIV=4 → each slot shows one FF/00 cycle followed by three lit cycles.
